// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART transmit port between two byte requesters.
// Latency: one cycle from IDLE to grant, combinational data mux while granted; backpressure passes straight to the granted requester.
module uart_tx_arbiter #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [7:0]           req0_data,
   input  logic                 req0_valid,
   input  logic                 req0_last,
   output logic                 req0_ready,
   input  logic [7:0]           req1_data,
   input  logic                 req1_valid,
   input  logic                 req1_last,
   output logic                 req1_ready,
   output logic [7:0]           uart_data,
   output logic                 uart_valid,
   input  logic                 uart_ready,
   input  logic                 clear_counts,
   output logic                 busy,
   output logic                 grant_id,
   output logic [CNT_WIDTH-1:0] count0,
   output logic [CNT_WIDTH-1:0] count1
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;
   logic   last_grant;
   logic   last_grant_nxt;
   logic   hs0;
   logic   hs1;

   assign hs0 = (state == GRANT0) && req0_valid && uart_ready;
   assign hs1 = (state == GRANT1) && req1_valid && uart_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= 1'b1;
      end else begin
         state      <= state_nxt;
         last_grant <= last_grant_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      last_grant_nxt = last_grant;
      uart_data      = 8'h00;
      uart_valid     = 1'b0;
      req0_ready     = 1'b0;
      req1_ready     = 1'b0;
      busy           = 1'b0;
      grant_id       = last_grant;
      case (state)
         IDLE: begin
            // On a tie the requester that was not served last wins
            if (req0_valid && req1_valid) begin
               state_nxt = last_grant ? GRANT0 : GRANT1;
            end else if (req0_valid) begin
               state_nxt = GRANT0;
            end else if (req1_valid) begin
               state_nxt = GRANT1;
            end
         end
         GRANT0: begin
            uart_data  = req0_data;
            uart_valid = req0_valid;
            req0_ready = uart_ready;
            busy       = 1'b1;
            grant_id   = 1'b0;
            if (hs0 && req0_last) begin
               state_nxt      = IDLE;
               last_grant_nxt = 1'b0;
            end
         end
         GRANT1: begin
            uart_data  = req1_data;
            uart_valid = req1_valid;
            req1_ready = uart_ready;
            busy       = 1'b1;
            grant_id   = 1'b1;
            if (hs1 && req1_last) begin
               state_nxt      = IDLE;
               last_grant_nxt = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Saturating counters; clear wins over a same-cycle handshake
   always_ff @(posedge clk) begin
      if (reset || clear_counts) begin
         count0 <= '0;
         count1 <= '0;
      end else begin
         if (hs0 && (count0 != '1)) begin
            count0 <= count0 + CNT_WIDTH'(1);
         end
         if (hs1 && (count1 != '1)) begin
            count1 <= count1 + CNT_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: packet-level reference ordering plus directed scenario checks.
module tb_uart_tx_arbiter;

   localparam int CW   = 2;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset;
   logic [7:0]    rq_data [2];
   logic          rq_valid[2];
   logic          rq_last [2];
   logic          rq_ready[2];
   logic [7:0]    uart_data;
   logic          uart_valid;
   logic          uart_ready;
   logic          clear_counts;
   logic          busy;
   logic          grant_id;
   logic [CW-1:0] count0;
   logic [CW-1:0] count1;

   int vectors     = 0;
   int miscompares = 0;

   logic [8:0] obs_q[$];
   logic [8:0] exp_q[$];

   logic [7:0] src_dat[2][32];
   logic       src_lst[2][32];
   int         src_gap[2][32];
   int         src_len[2];

   always #5 clk = ~clk;

   uart_tx_arbiter #(.CNT_WIDTH(CW)) dut (
      .clk          (clk),
      .reset        (reset),
      .req0_data    (rq_data[0]),
      .req0_valid   (rq_valid[0]),
      .req0_last    (rq_last[0]),
      .req0_ready   (rq_ready[0]),
      .req1_data    (rq_data[1]),
      .req1_valid   (rq_valid[1]),
      .req1_last    (rq_last[1]),
      .req1_ready   (rq_ready[1]),
      .uart_data    (uart_data),
      .uart_valid   (uart_valid),
      .uart_ready   (uart_ready),
      .clear_counts (clear_counts),
      .busy         (busy),
      .grant_id     (grant_id),
      .count0       (count0),
      .count1       (count1)
   );

   // Every byte the UART accepts, tagged with the port it came from
   always @(negedge clk) begin
      if (!reset && uart_valid && uart_ready) obs_q.push_back({grant_id, uart_data});
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      reset        = 1'b1;
      clear_counts = 1'b0;
      uart_ready   = 1'b1;
      for (int n = 0; n < 2; n++) begin
         rq_valid[n] = 1'b0;
         rq_last[n]  = 1'b0;
         rq_data[n]  = 8'h00;
      end
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // Presents requester n's byte list; holds each byte until accepted
   task automatic drive(input int n);
      for (int i = 0; i < src_len[n]; i++) begin
         int t;
         t = 0;
         if (src_gap[n][i] > 0) begin
            rq_valid[n] = 1'b0;
            repeat (src_gap[n][i]) @(posedge clk);
            #1;
         end
         rq_data[n]  = src_dat[n][i];
         rq_last[n]  = src_lst[n][i];
         rq_valid[n] = 1'b1;
         @(negedge clk);
         while (!rq_ready[n] && t < 300) begin
            @(negedge clk);
            t++;
         end
         vectors++;
         if (!rq_ready[n]) begin
            miscompares++;
            $display("FAIL drive%0d_byte%0d: ready=0 after 300 cycles, required 1", n, i);
            rq_valid[n] = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
      end
      rq_valid[n] = 1'b0;
      rq_last[n]  = 1'b0;
   endtask

   task automatic run_sources(input bit rand_rdy);
      bit done;
      done = 1'b0;
      fork
         begin
            fork
               drive(0);
               drive(1);
            join
            done = 1'b1;
         end
         begin
            while (rand_rdy && !done) begin
               @(posedge clk);
               #1;
               uart_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      uart_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
   endtask

   // Reference order: whenever both have work, whole packets alternate, port 0 first after reset
   task automatic build_expected();
      int pos[2];
      int turn;
      pos[0] = 0;
      pos[1] = 0;
      turn   = 0;
      exp_q.delete();
      while (pos[0] < src_len[0] || pos[1] < src_len[1]) begin
         int  who;
         logic fin;
         who = (pos[turn] < src_len[turn]) ? turn : 1 - turn;
         fin = 1'b0;
         while (!fin && pos[who] < src_len[who]) begin
            exp_q.push_back({who[0], src_dat[who][pos[who]]});
            fin = src_lst[who][pos[who]];
            pos[who]++;
         end
         turn = 1 - who;
      end
   endtask

   task automatic set_byte(input int n, input int i, input logic [7:0] d, input logic l, input int g);
      src_dat[n][i] = d;
      src_lst[n][i] = l;
      src_gap[n][i] = g;
   endtask

   task automatic test_reset();
      reset       = 1'b1;
      rq_valid[0] = 1'b1;
      rq_data[0]  = 8'hE5;
      rq_last[0]  = 1'b1;
      uart_ready  = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      vectors++;
      if ({busy, grant_id, uart_valid, uart_data, rq_ready[0], rq_ready[1]} !== {1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_outputs: busy=%b grant_id=%b uart_valid=%b uart_data=%h ready=%b%b, required 0 1 0 00 00",
                  busy, grant_id, uart_valid, uart_data, rq_ready[0], rq_ready[1]);
      end
      vectors++;
      if (count0 !== '0 || count1 !== '0) begin
         miscompares++;
         $display("FAIL reset_counts: count0=%0d count1=%0d, required 0 0", count0, count1);
      end
      rq_valid[0] = 1'b0;
      do_reset();
   endtask

   task automatic test_single();
      int base;
      do_reset();
      base       = obs_q.size();
      src_len[0] = 1;
      src_len[1] = 0;
      set_byte(0, 0, 8'h7A, 1'b1, 0);
      build_expected();
      run_sources(1'b0);
      vectors++;
      if (obs_q.size() - base != 1 || obs_q[base] !== 9'h07A) begin
         miscompares++;
         $display("FAIL single_byte: got %0d bytes first=%h, required 1 byte 07A", obs_q.size() - base, obs_q[base]);
      end
      vectors++;
      if (int'(count0) !== 1 || int'(count1) !== 0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL single_status: count0=%0d count1=%0d busy=%b, required 1 0 0", count0, count1, busy);
      end
   endtask

   task automatic test_tie();
      int base;
      do_reset();
      base       = obs_q.size();
      src_len[0] = 2;
      src_len[1] = 2;
      set_byte(0, 0, 8'h11, 1'b1, 0);
      set_byte(0, 1, 8'h33, 1'b1, 0);
      set_byte(1, 0, 8'h22, 1'b1, 0);
      set_byte(1, 1, 8'h44, 1'b1, 0);
      build_expected();
      run_sources(1'b0);
      vectors++;
      if (obs_q.size() - base != exp_q.size()) begin
         miscompares++;
         $display("FAIL tie_len: got %0d bytes, required %0d", obs_q.size() - base, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
         vectors++;
         if (obs_q[base + i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL tie_order[%0d]: got %h, required %h", i, obs_q[base + i], exp_q[i]);
         end
      end
   endtask

   task automatic test_lock();
      int base;
      bit d0;
      do_reset();
      base       = obs_q.size();
      d0         = 1'b0;
      src_len[0] = 3;
      src_len[1] = 1;
      set_byte(0, 0, 8'hA1, 1'b0, 0);
      set_byte(0, 1, 8'hA2, 1'b0, 5);
      set_byte(0, 2, 8'hA3, 1'b1, 0);
      set_byte(1, 0, 8'h55, 1'b1, 0);
      build_expected();
      fork
         begin
            drive(0);
            d0 = 1'b1;
         end
         drive(1);
         begin
            while (!d0) begin
               @(negedge clk);
               if (!d0) begin
                  vectors++;
                  if (rq_ready[1] || (!rq_valid[0] && uart_valid)) begin
                     miscompares++;
                     $display("FAIL lock_block: req1_ready=%b uart_valid=%b req0_valid=%b, required req1_ready=0 and uart_valid following req0_valid",
                              rq_ready[1], uart_valid, rq_valid[0]);
                  end
               end
            end
         end
      join
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < exp_q.size(); i++) begin
         vectors++;
         if (base + i >= obs_q.size() || obs_q[base + i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL lock_order[%0d]: got %h, required %h", i,
                     (base + i < obs_q.size()) ? obs_q[base + i] : 9'h1FF, exp_q[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      uart_ready  = 1'b0;
      rq_data[1]  = 8'h3C;
      rq_last[1]  = 1'b1;
      rq_valid[1] = 1'b1;
      @(posedge clk);
      #1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         vectors++;
         if ({uart_valid, uart_data, rq_ready[1], busy, grant_id} !== {1'b1, 8'h3C, 1'b0, 1'b1, 1'b1} || int'(count1) !== 0) begin
            miscompares++;
            $display("FAIL bp_hold[%0d]: uart_valid=%b uart_data=%h req1_ready=%b busy=%b grant_id=%b count1=%0d, required 1 3c 0 1 1 0",
                     c, uart_valid, uart_data, rq_ready[1], busy, grant_id, count1);
         end
         @(posedge clk);
         #1;
      end
      uart_ready = 1'b1;
      @(negedge clk);
      vectors++;
      if (rq_ready[1] !== 1'b1 || uart_data !== 8'h3C) begin
         miscompares++;
         $display("FAIL bp_release: req1_ready=%b uart_data=%h, required 1 3c", rq_ready[1], uart_data);
      end
      @(posedge clk);
      #1;
      rq_valid[1] = 1'b0;
      @(negedge clk);
      vectors++;
      if (int'(count1) !== 1 || busy !== 1'b0 || int'(count0) !== 0) begin
         miscompares++;
         $display("FAIL bp_after: count1=%0d busy=%b count0=%0d, required 1 0 0", count1, busy, count0);
      end
   endtask

   task automatic test_reset_mid();
      int base;
      do_reset();
      rq_last[0] = 1'b0;
      for (int i = 0; i < 2; i++) begin
         int t;
         t           = 0;
         rq_data[0]  = 8'hB0 + 8'(i);
         rq_valid[0] = 1'b1;
         @(negedge clk);
         while (!rq_ready[0] && t < 50) begin
            @(negedge clk);
            t++;
         end
         @(posedge clk);
         #1;
      end
      vectors++;
      if (int'(count0) !== 2 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL midpkt_progress: count0=%0d busy=%b, required 2 1", count0, busy);
      end
      rq_data[0] = 8'hB2;
      reset      = 1'b1;
      @(posedge clk);
      #1;
      reset       = 1'b0;
      rq_valid[0] = 1'b0;
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || grant_id !== 1'b1 || uart_valid !== 1'b0 || int'(count0) !== 0) begin
         miscompares++;
         $display("FAIL midpkt_reset: busy=%b grant_id=%b uart_valid=%b count0=%0d, required 0 1 0 0",
                  busy, grant_id, uart_valid, count0);
      end
      base        = obs_q.size();
      rq_data[1]  = 8'h99;
      rq_last[1]  = 1'b1;
      rq_valid[1] = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      vectors++;
      if (uart_valid !== 1'b1 || uart_data !== 8'h99 || rq_ready[1] !== 1'b1) begin
         miscompares++;
         $display("FAIL midpkt_next: uart_valid=%b uart_data=%h req1_ready=%b, required 1 99 1", uart_valid, uart_data, rq_ready[1]);
      end
      @(posedge clk);
      #1;
      rq_valid[1] = 1'b0;
      vectors++;
      if (int'(count1) !== 1 || int'(count0) !== 0 || obs_q.size() - base != 1) begin
         miscompares++;
         $display("FAIL midpkt_counts: count1=%0d count0=%0d sent=%0d, required 1 0 1", count1, count0, obs_q.size() - base);
      end
   endtask

   task automatic test_counters();
      int base;
      do_reset();
      src_len[0] = 5;
      src_len[1] = 0;
      for (int i = 0; i < 5; i++) set_byte(0, i, 8'($urandom), 1'b1, 0);
      run_sources(1'b0);
      vectors++;
      if (int'(count0) !== ((5 > CMAX) ? CMAX : 5)) begin
         miscompares++;
         $display("FAIL cnt_saturate: count0=%0d, required %0d", count0, (5 > CMAX) ? CMAX : 5);
      end
      clear_counts = 1'b1;
      @(posedge clk);
      #1;
      clear_counts = 1'b0;
      vectors++;
      if (int'(count0) !== 0) begin
         miscompares++;
         $display("FAIL cnt_clear: count0=%0d, required 0", count0);
      end
      src_len[0] = 1;
      run_sources(1'b0);
      vectors++;
      if (int'(count0) !== 1) begin
         miscompares++;
         $display("FAIL cnt_one: count0=%0d, required 1", count0);
      end
      base        = obs_q.size();
      rq_data[0]  = 8'h5A;
      rq_last[0]  = 1'b1;
      rq_valid[0] = 1'b1;
      @(posedge clk);
      #1;
      clear_counts = 1'b1;
      @(posedge clk);
      #1;
      clear_counts = 1'b0;
      rq_valid[0]  = 1'b0;
      vectors++;
      if (int'(count0) !== 0 || obs_q.size() - base != 1) begin
         miscompares++;
         $display("FAIL cnt_clear_vs_inc: count0=%0d sent=%0d, required 0 1", count0, obs_q.size() - base);
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 25; it++) begin
         int base;
         int e0;
         int e1;
         do_reset();
         base = obs_q.size();
         for (int n = 0; n < 2; n++) begin
            int np;
            np         = $urandom_range(1, 4);
            src_len[n] = 0;
            for (int p = 0; p < np; p++) begin
               int len;
               len = $urandom_range(1, 4);
               for (int b = 0; b < len; b++) begin
                  set_byte(n, src_len[n], 8'($urandom), (b == len - 1),
                           (b == 0) ? 0 : (($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0));
                  src_len[n]++;
               end
            end
         end
         build_expected();
         run_sources(1'b1);
         vectors++;
         if (obs_q.size() - base != exp_q.size()) begin
            miscompares++;
            $display("FAIL rand%0d_len: got %0d bytes, required %0d", it, obs_q.size() - base, exp_q.size());
         end
         for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[base + i] !== exp_q[i]) begin
               miscompares++;
               $display("FAIL rand%0d_order[%0d]: got %h, required %h", it, i, obs_q[base + i], exp_q[i]);
            end
         end
         e0 = (src_len[0] > CMAX) ? CMAX : src_len[0];
         e1 = (src_len[1] > CMAX) ? CMAX : src_len[1];
         vectors++;
         if (int'(count0) !== e0 || int'(count1) !== e1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rand%0d_counts: count0=%0d count1=%0d busy=%b, required %0d %0d 0", it, count0, count1, busy, e0, e1);
         end
      end
   endtask

   initial begin
      reset        = 1'b1;
      clear_counts = 1'b0;
      uart_ready   = 1'b0;
      for (int n = 0; n < 2; n++) begin
         rq_valid[n] = 1'b0;
         rq_last[n]  = 1'b0;
         rq_data[n]  = 8'h00;
         src_len[n]  = 0;
      end
      test_reset();
      test_single();
      test_tie();
      test_lock();
      test_backpressure();
      test_reset_mid();
      test_counters();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
